// File: rtl/seg_mux_capture.sv
// ---------------------------------------------------------------------------
// seg_mux_capture
//   Receive side of a 4-digit multiplexed 7-segment display interface.
//   The scanned segment bus and the active-low digit selects are
//   synchronised. Once a value has been stable for SETTLE clocks it is
//   de-multiplexed into one of four latched 7-bit patterns. Each latched
//   pattern is decoded to a hex nibble. A digit that is not refreshed for
//   TIMEOUT clocks is blanked.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous reset, active low
//   segment     scanned segment bus, active high, bit0=a .. bit6=g
//   indicator   digit selects, active low, one-hot-low while a digit drives
//   digit0..3   last captured segment pattern of each digit
//   hex0..3     decoded nibble of each digit (0 when the pattern is unknown)
//   valid       bit N set while digitN decodes as hex and has not timed out
//   frame_done  one-clock pulse on every capture of digit 3
//   sel_err     one-clock pulse when a settled select has two or more lows
// ---------------------------------------------------------------------------
module seg_mux_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segment,
  input  logic [3:0] indicator,
  output logic [6:0] digit0,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] digit3,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       sel_err
);

  localparam int              SW         = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_MAX = SW'(SETTLE);
  localparam logic [SW-1:0]   SETTLE_CAP = SW'(SETTLE - 1);
  localparam logic [TW-1:0]   TO_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0]   TO_HIT     = TW'(TIMEOUT - 1);
  // Idle bus value: all selects high (blanking), segments dark.
  localparam logic [10:0]     BUS_IDLE   = {4'hF, 7'h00};

  typedef enum logic [1:0] {
    ST_GAP      = 2'd0,
    ST_SETTLING = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  // Returns {recognised, nibble}; unknown patterns give 5'h00.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h27:   r = 5'h17;  // seven drawn with segment f lit
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [10:0]         s1_q, s2_q, prev_q;
  logic [SW-1:0]       stab_q, stab_d;
  state_e              state_q, state_d;
  logic [3:0][6:0]     digit_q, digit_d;
  logic [3:0][3:0]     hex_q, hex_d;
  logic [3:0]          valid_q, valid_d;
  logic [3:0][TW-1:0]  tcnt_q, tcnt_d;
  logic                fd_q, fd_d, se_q, se_d;

  logic [3:0]          sel_s;
  logic [6:0]          seg_s;
  logic                changed_s, cap_cond_s, capture_s, onehot_s, multi_s;
  logic [2:0]          low_cnt_s;
  logic [4:0]          dec_s;

  assign sel_s      = s2_q[10:7];
  assign seg_s      = s2_q[6:0];
  assign changed_s  = (s2_q != prev_q);
  // Fires on exactly one cycle of a dwell: the counter passes SETTLE-1 once.
  assign cap_cond_s = !changed_s && (stab_q == SETTLE_CAP);
  assign capture_s  = (state_q == ST_SETTLING) && cap_cond_s;
  assign onehot_s   = capture_s && (low_cnt_s == 3'd1);
  assign multi_s    = capture_s && (low_cnt_s >= 3'd2);
  assign dec_s      = decode_seg(seg_s);

  // Count the active (low) select lines of the synchronised bus.
  always_comb begin
    low_cnt_s = 3'd0;
    for (int i = 0; i < 4; i++) begin
      low_cnt_s = low_cnt_s + {2'b00, ~sel_s[i]};
    end
  end

  // Stability counter: restart on any bus change, saturate at SETTLE.
  always_comb begin
    if (changed_s) begin
      stab_d = '0;
    end else if (stab_q != SETTLE_MAX) begin
      stab_d = stab_q + SW'(1);
    end else begin
      stab_d = stab_q;
    end
  end

  // Dwell tracking FSM next state.
  always_comb begin
    state_d = state_q;
    if (changed_s) begin
      if (sel_s == 4'hF) begin
        state_d = ST_GAP;
      end else begin
        state_d = ST_SETTLING;
      end
    end else begin
      case (state_q)
        ST_GAP:      state_d = ST_GAP;
        ST_SETTLING: begin
          if (cap_cond_s) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SETTLING;
          end
        end
        ST_HOLD:     state_d = ST_HOLD;
        default:     state_d = ST_GAP;
      endcase
    end
  end

  // Per-digit capture and timeout; a capture beats a timeout on the same digit.
  always_comb begin
    digit_d = digit_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    tcnt_d  = tcnt_q;
    for (int n = 0; n < 4; n++) begin
      if (onehot_s && !sel_s[n]) begin
        digit_d[n]              = seg_s;
        {valid_d[n], hex_d[n]}  = dec_s;
        tcnt_d[n]               = '0;
      end else if (tcnt_q[n] >= TO_HIT) begin
        digit_d[n] = 7'h00;
        hex_d[n]   = 4'h0;
        valid_d[n] = 1'b0;
        tcnt_d[n]  = TO_MAX;
      end else begin
        tcnt_d[n]  = tcnt_q[n] + TW'(1);
      end
    end
    fd_d = onehot_s && !sel_s[3];
    se_d = multi_s;
  end

  // Input synchroniser, previous-value register, stability counter, FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= BUS_IDLE;
      s2_q    <= BUS_IDLE;
      prev_q  <= BUS_IDLE;
      stab_q  <= '0;
      state_q <= ST_GAP;
    end else begin
      s1_q    <= {indicator, segment};
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      stab_q  <= stab_d;
      state_q <= state_d;
    end
  end

  // Registered outputs and per-digit timeout counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      hex_q   <= '0;
      valid_q <= 4'h0;
      tcnt_q  <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      digit_q <= digit_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      tcnt_q  <= tcnt_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

  assign digit0     = digit_q[0];
  assign digit1     = digit_q[1];
  assign digit2     = digit_q[2];
  assign digit3     = digit_q[3];
  assign hex0       = hex_q[0];
  assign hex1       = hex_q[1];
  assign hex2       = hex_q[2];
  assign hex3       = hex_q[3];
  assign valid      = valid_q;
  assign frame_done = fd_q;
  assign sel_err    = se_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// ---------------------------------------------------------------------------
// tb_seg_mux_capture
//   Two instances: u_a (SETTLE=4, TIMEOUT=1024) for scanning, latency,
//   glitch, select-error and reset behaviour; u_b (SETTLE=2, TIMEOUT=16) for
//   digit blanking on timeout. Stimulus pushes the expected output snapshot
//   and the cycle at which it must appear; a monitor pops and compares
//   whenever an instance shows a pulse or a change of its latched outputs.
// ---------------------------------------------------------------------------
module tb_seg_mux_capture;

  typedef struct packed {
    logic [3:0][6:0] dig;
    logic [3:0][3:0] hx;
    logic [3:0]      vl;
    logic            fd;
    logic            se;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic [3:0] ind_a, ind_b;
  logic [6:0] seg_a, seg_b;

  logic [6:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
  logic [3:0] a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
  logic [3:0] a_vl, b_vl;
  logic       a_fd, a_se, b_fd, b_se;

  seg_mux_capture #(.SETTLE(4), .TIMEOUT(1024), .TW(11)) u_a (
    .clk(clk), .rst_n(rst_a_n), .segment(seg_a), .indicator(ind_a),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
    .hex0(a_h0), .hex1(a_h1), .hex2(a_h2), .hex3(a_h3),
    .valid(a_vl), .frame_done(a_fd), .sel_err(a_se)
  );

  seg_mux_capture #(.SETTLE(2), .TIMEOUT(16), .TW(5)) u_b (
    .clk(clk), .rst_n(rst_b_n), .segment(seg_b), .indicator(ind_b),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
    .hex0(b_h0), .hex1(b_h1), .hex2(b_h2), .hex3(b_h3),
    .valid(b_vl), .frame_done(b_fd), .sel_err(b_se)
  );

  obs_t cur_a, cur_b;
  assign cur_a = {a_d3, a_d2, a_d1, a_d0, a_h3, a_h2, a_h1, a_h0, a_vl, a_fd, a_se};
  assign cur_b = {b_d3, b_d2, b_d1, b_d0, b_h3, b_h2, b_h1, b_h0, b_vl, b_fd, b_se};

  exp_t q_a[$];
  exp_t q_b[$];
  obs_t m_a = '0;
  obs_t m_b = '0;
  obs_t prv_a = '0;
  obs_t prv_b = '0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected decode of a segment pattern: {recognised, nibble}.
  function automatic logic [4:0] exp_decode(input logic [6:0] s);
    case (s)
      7'h3F: return 5'h10;  7'h06: return 5'h11;  7'h5B: return 5'h12;
      7'h4F: return 5'h13;  7'h66: return 5'h14;  7'h6D: return 5'h15;
      7'h7D: return 5'h16;  7'h07: return 5'h17;  7'h27: return 5'h17;
      7'h7F: return 5'h18;  7'h6F: return 5'h19;  7'h77: return 5'h1A;
      7'h7C: return 5'h1B;  7'h39: return 5'h1C;  7'h5E: return 5'h1D;
      7'h79: return 5'h1E;  7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  task automatic check_inst(input int id, input obs_t c, input obs_t p);
    exp_t e;
    bit   empty;
    if (c.fd || c.se || ({c.dig, c.hx, c.vl} !== {p.dig, p.hx, p.vl})) begin
      checks++;
      empty = (id == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      if (empty) begin
        errors++;
        $display("FAIL unexpected_event inst%0d: got cyc %0d out %h, required no event", id, cyc, c);
      end else begin
        if (id == 0) e = q_a.pop_front();
        else         e = q_b.pop_front();
        if ((e.cyc != cyc) || (c !== e.o)) begin
          errors++;
          $display("FAIL event inst%0d: got cyc %0d out %h, required cyc %0d out %h",
                   id, cyc, c, e.cyc, e.o);
        end
      end
    end
  endtask

  // Monitor: compare every visible output event against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check_inst(0, cur_a, prv_a);
      check_inst(1, cur_b, prv_b);
    end
    prv_a <= cur_a;
    prv_b <= cur_b;
  end

  task automatic push(input int id, input int at, input obs_t nx, input obs_t old);
    exp_t e;
    if (nx.fd || nx.se || ({nx.dig, nx.hx, nx.vl} != {old.dig, old.hx, old.vl})) begin
      e.cyc = at;
      e.o   = nx;
      if (id == 0) q_a.push_back(e);
      else         q_b.push_back(e);
    end
  endtask

  // Expected effect of a settled bus value {ind,seg} appearing at cycle at.
  task automatic model_capture(input int id, input logic [3:0] ind, input logic [6:0] seg,
                               input int at);
    obs_t old, nx;
    int   zeros, pos;
    logic [4:0] d;
    old = (id == 0) ? m_a : m_b;
    nx  = old;
    zeros = 0;
    pos   = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ind[i]) begin
        zeros++;
        pos = i;
      end
    end
    if (zeros == 1) begin
      d = exp_decode(seg);
      nx.dig[pos] = seg;
      nx.hx[pos]  = d[3:0];
      nx.vl[pos]  = d[4];
      nx.fd       = (pos == 3);
    end else if (zeros >= 2) begin
      nx.se = 1'b1;
    end
    push(id, at, nx, old);
    nx.fd = 1'b0;
    nx.se = 1'b0;
    if (id == 0) m_a = nx;
    else         m_b = nx;
  endtask

  task automatic model_timeout(input int id, input int n, input int at);
    obs_t old, nx;
    old = (id == 0) ? m_a : m_b;
    nx  = old;
    nx.dig[n] = 7'h00;
    nx.hx[n]  = 4'h0;
    nx.vl[n]  = 1'b0;
    push(id, at, nx, old);
    if (id == 0) m_a = nx;
    else         m_b = nx;
  endtask

  task automatic drive(input int id, input logic [3:0] ind, input logic [6:0] seg);
    if (id == 0) begin ind_a = ind; seg_a = seg; end
    else         begin ind_b = ind; seg_b = seg; end
  endtask

  // Called at a falling edge: drive, predict capture at cyc+SETTLE+3, hold n clocks.
  task automatic dwell(input int id, input logic [3:0] ind, input logic [6:0] seg, input int n);
    drive(id, ind, seg);
    model_capture(id, ind, seg, cyc + ((id == 0) ? 4 : 2) + 3);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic at_b(input int t, input logic [3:0] ind, input logic [6:0] seg);
    wait_until(t);
    drive(1, ind, seg);
    model_capture(1, ind, seg, t + 5);
  endtask

  logic [3:0] sel_t [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] pat_t [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive(0, 4'hF, 7'h00);
    drive(1, 4'hF, 7'h00);
    repeat (3) @(negedge clk);

    checks++;
    if (cur_a !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h, required 0", cur_a);
    end
    checks++;
    if (cur_b !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h, required 0", cur_b);
    end

    rst_a_n = 1'b1;
    mon_en  = 1'b1;
    repeat (3) @(negedge clk);

    // Two full scans of 0,1,2,3 with an 8-clock dwell.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) dwell(0, sel_t[i], pat_t[i], 8);
    end

    // Long holds: capture latency on digit 0, single capture on digit 3.
    dwell(0, 4'b1110, 7'h6D, 20);
    dwell(0, 4'b0111, 7'h6D, 30);

    // Segment jitter faster than the settle window: no capture.
    for (int i = 0; i < 10; i++) begin
      drive(0, 4'b1110, (i % 2 == 0) ? 7'h3F : 7'h06);
      repeat (2) @(negedge clk);
    end
    dwell(0, 4'hF, 7'h00, 10);

    // Two selects low at once: one sel_err pulse, digits unchanged.
    dwell(0, 4'b1100, 7'h5B, 10);
    dwell(0, 4'hF, 7'h00, 6);

    // Reset in the middle of a dwell, then a stable select after release.
    drive(0, 4'b1110, 7'h06);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_a_n = 1'b0;
    begin
      obs_t old;
      old = m_a;
      m_a = '0;
      push(0, cyc, m_a, old);
    end
    @(negedge clk);
    drive(0, 4'b1101, 7'h5B);
    repeat (4) @(negedge clk);
    rst_a_n = 1'b1;
    model_capture(0, 4'b1101, 7'h5B, cyc + 7);
    repeat (12) @(negedge clk);
    dwell(0, 4'hF, 7'h00, 4);

    // Timeout instance: stop refreshing digit 2, then restore it.
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);
    b = cyc;
    at_b(b + 0,  4'b1110, 7'h6D);
    at_b(b + 3,  4'b1101, 7'h77);
    at_b(b + 6,  4'b1011, 7'h39);
    at_b(b + 9,  4'b0111, 7'h79);
    at_b(b + 12, 4'b1110, 7'h6D);
    at_b(b + 15, 4'b1101, 7'h77);
    at_b(b + 18, 4'b0111, 7'h79);
    at_b(b + 21, 4'b1110, 7'h6D);
    model_timeout(1, 2, b + 27);
    at_b(b + 24, 4'b1101, 7'h77);
    at_b(b + 27, 4'b0111, 7'h79);
    at_b(b + 30, 4'b1110, 7'h6D);
    at_b(b + 33, 4'b1101, 7'h77);
    at_b(b + 36, 4'b1011, 7'h39);
    at_b(b + 39, 4'b0111, 7'h79);
    at_b(b + 42, 4'hF, 7'h00);
    model_timeout(1, 0, b + 51);
    model_timeout(1, 1, b + 54);
    model_timeout(1, 2, b + 57);
    model_timeout(1, 3, b + 60);

    wait_until(b + 64);
    #1;
    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL pending_a: got %0d events outstanding, required 0", q_a.size());
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL pending_b: got %0d events outstanding, required 0", q_b.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
